sha256_padder: RTL and testbench



---
 rtl/sha256_padder.sv | 147 ++++++++++++++
 tb/tb_sha256_padder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit big-endian words into 512-bit blocks,
// appends the 0x80 marker, zero fill and 64-bit bit length, and flags first/last blocks.
module sha256_padder #(
  parameter int unsigned LEN_W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk,
  output logic         blk_new,
  output logic         blk_last
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] SEND  = 1'b1;

  logic [0:0]       state;
  logic [3:0]       idx;
  logic [LEN_W-1:0] byte_cnt;
  logic [LEN_W-1:0] cnt_next;
  logic             first;
  logic             extra_pending;
  logic             spill;
  logic [31:0]      slot      [16];
  logic [31:0]      slot_next [16];
  logic [2:0]       nb;
  logic [4:0]       used;
  logic [31:0]      keep_mask;
  logic [31:0]      marker;
  logic [31:0]      word_in;
  logic [63:0]      bit_len;
  logic [63:0]      bit_len_cur;

  assign in_ready  = (state == ACCUM);
  assign blk_valid = (state == SEND);

  // Non-final beats always carry four bytes; oversized counts saturate at four.
  assign nb = !in_last ? 3'd4 : ((in_bytes > 3'd4) ? 3'd4 : in_bytes);

  always_comb begin
    keep_mask = '1;
    marker    = '0;
    case (nb)
      3'd0: begin keep_mask = 32'h0000_0000; marker = 32'h8000_0000; end
      3'd1: begin keep_mask = 32'hFF00_0000; marker = 32'h0080_0000; end
      3'd2: begin keep_mask = 32'hFFFF_0000; marker = 32'h0000_8000; end
      3'd3: begin keep_mask = 32'hFFFF_FF00; marker = 32'h0000_0080; end
      default: begin keep_mask = '1; marker = '0; end
    endcase
  end

  assign word_in     = (in_data & keep_mask) | (in_last ? marker : 32'h0);
  assign used        = (nb == 3'd4) ? ({1'b0, idx} + 5'd2) : ({1'b0, idx} + 5'd1);
  assign cnt_next    = byte_cnt + LEN_W'(nb);
  assign bit_len     = 64'(cnt_next) << 3;
  assign bit_len_cur = 64'(byte_cnt) << 3;

  // Slot image after accepting the current beat, including padding when it is the last.
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      slot_next[i] = slot[i];
      if (i == 32'(idx)) begin
        slot_next[i] = word_in;
      end else if (in_last && (i > 32'(idx))) begin
        if ((nb == 3'd4) && (i == 32'(idx) + 1)) slot_next[i] = 32'h8000_0000;
        else                                     slot_next[i] = '0;
      end
    end
    if (in_last && (used <= 5'd14)) begin
      slot_next[14] = bit_len[63:32];
      slot_next[15] = bit_len[31:0];
    end
  end

  always_comb begin
    blk = '0;
    for (int unsigned i = 0; i < 16; i++) blk[511 - 32*i -: 32] = slot[i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= ACCUM;
      idx           <= '0;
      byte_cnt      <= '0;
      first         <= 1'b1;
      extra_pending <= 1'b0;
      spill         <= 1'b0;
      blk_new       <= 1'b0;
      blk_last      <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) slot[i] <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            for (int unsigned i = 0; i < 16; i++) slot[i] <= slot_next[i];
            byte_cnt <= cnt_next;
            if (!in_last && (idx != 4'd15)) begin
              idx <= idx + 4'd1;
            end else begin
              state   <= SEND;
              idx     <= '0;
              blk_new <= first;
              if (!in_last) begin
                blk_last <= 1'b0;
              end else if (used <= 5'd14) begin
                blk_last <= 1'b1;
              end else begin
                blk_last      <= 1'b0;
                extra_pending <= 1'b1;
                spill         <= (used == 5'd17);
              end
            end
          end
        end
        default: begin
          if (blk_ready) begin
            if (extra_pending) begin
              // Length-only trailer block; the marker lands here only when it spilled.
              slot[0] <= spill ? 32'h8000_0000 : 32'h0;
              for (int unsigned i = 1; i < 14; i++) slot[i] <= '0;
              slot[14]      <= bit_len_cur[63:32];
              slot[15]      <= bit_len_cur[31:0];
              blk_new       <= 1'b0;
              blk_last      <= 1'b1;
              extra_pending <= 1'b0;
            end else begin
              state <= ACCUM;
              if (blk_last) begin
                byte_cnt <= '0;
                first    <= 1'b1;
              end else begin
                first <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: a byte-level SHA-256 padding model predicts every block,
// and a negedge monitor compares each delivered block and its flags against it.
module tb_sha256_padder;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [2:0]   in_bytes = '0;
  logic         blk_valid;
  logic         blk_ready = 1'b1;
  logic [511:0] blk;
  logic         blk_new;
  logic         blk_last;

  always #5 clk_i = ~clk_i;

  sha256_padder #(.LEN_W(32)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk       (blk),
    .blk_new   (blk_new),
    .blk_last  (blk_last)
  );

  typedef struct packed {
    logic [511:0] data;
    logic         nw;
    logic         lst;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  msg[$];
  logic [31:0] junk = 32'hFFFF_FFFF;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Standard SHA-256 padding on the byte stream, then cut into 64-byte blocks.
  task automatic model_push();
    logic [7:0]  p[$];
    logic [63:0] bits;
    exp_t        e;
    int unsigned nblk;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int unsigned k = 0; k < 8; k++) p.push_back(bits[63 - 8*k -: 8]);
    nblk = p.size() / 64;
    for (int unsigned b = 0; b < nblk; b++) begin
      e.data = '0;
      for (int unsigned j = 0; j < 64; j++) e.data[511 - 8*j -: 8] = p[b*64 + j];
      e.nw  = (b == 0);
      e.lst = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic set_msg(input int unsigned n, input int unsigned seed);
    msg.delete();
    for (int unsigned i = 0; i < n; i++) msg.push_back(8'(i * 13 + seed));
  endtask

  task automatic put_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    bit          ok;
    int unsigned t;
    in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nb;
    ok = 1'b0; t = 0;
    while (!ok && t < 500) begin
      @(negedge clk_i);
      ok = in_ready;
      @(posedge clk_i);
      #1;
      t++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL in_accept: got no in_ready, expected acceptance within 500 cycles");
    end
  endtask

  task automatic drive_msg(input bit big_code, input int unsigned stop_words);
    int unsigned L;
    int unsigned nw;
    logic [31:0] d;
    logic [2:0]  nb;
    L  = msg.size();
    nw = (L == 0) ? 1 : (L + 3) / 4;
    for (int unsigned w = 0; w < nw && w < stop_words; w++) begin
      for (int unsigned j = 0; j < 4; j++)
        d[31 - 8*j -: 8] = (4*w + j < L) ? msg[4*w + j] : junk[31 - 8*j -: 8];
      if (w == nw - 1) begin
        nb = 3'(L - 4*w);
        if (big_code && nb == 3'd4) nb = 3'd7;
        put_word(d, 1'b1, nb);
      end else begin
        put_word(d, 1'b0, 3'd1);
      end
    end
  endtask

  task automatic drain();
    int unsigned t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk_i);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: got %0d blocks outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_valid();
    int unsigned t;
    t = 0;
    while (!blk_valid && t < 50) begin
      @(posedge clk_i);
      #1;
      t++;
    end
    chk("blk_valid_rise", blk_valid, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_blk_valid"}, blk_valid, 1'b0);
    chk({tag, "_blk"},       blk,       '0);
    chk({tag, "_blk_new"},   blk_new,   1'b0);
    chk({tag, "_blk_last"},  blk_last,  1'b0);
    chk({tag, "_in_ready"},  in_ready,  1'b1);
  endtask

  // Compare process: every delivered block against the model, held outputs while stalled.
  initial begin
    exp_t e;
    exp_t prev;
    bit   held;
    held = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk_i);
      if (rst_ni && mon_en) begin
        chk("in_ready_vs_valid", in_ready, !blk_valid);
        if (blk_valid) begin
          if (held) begin
            chk("hold_blk", blk, prev.data);
            chk("hold_new", blk_new, prev.nw);
            chk("hold_last", blk_last, prev.lst);
          end
          if (blk_ready) begin
            held = 1'b0;
            if (exp_q.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL unexpected_block: got %0h, expected no block", blk);
            end else begin
              e = exp_q.pop_front();
              chk("blk", blk, e.data);
              chk("blk_new", blk_new, e.nw);
              chk("blk_last", blk_last, e.lst);
            end
          end else begin
            held      = 1'b1;
            prev.data = blk;
            prev.nw   = blk_new;
            prev.lst  = blk_last;
          end
        end else begin
          held = 1'b0;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk_reset_outputs("rst");
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("rst_release_in_ready", in_ready, 1'b1);
    mon_en = 1'b1;

    // Empty message: junk data must be fully masked.
    msg.delete(); junk = 32'hDEAD_BEEF;
    model_push();
    chk("model_empty_nblk", exp_q.size(), 1);
    chk("model_empty_w0", exp_q[0].data[511:480], 32'h8000_0000);
    chk("model_empty_w15", exp_q[0].data[31:0], 32'h0);
    drive_msg(1'b0, 1000);
    drain();

    // "abc"
    msg = '{8'h61, 8'h62, 8'h63}; junk = 32'hFFFF_FFFF;
    model_push();
    chk("model_abc_w0", exp_q[0].data[511:480], 32'h6162_6380);
    chk("model_abc_w15", exp_q[0].data[31:0], 32'h0000_0018);
    drive_msg(1'b0, 1000);
    drain();

    // 56 bytes: marker in word14, length in a second block
    set_msg(56, 5);
    model_push();
    chk("model_56_nblk", exp_q.size(), 2);
    chk("model_56_b1w14", exp_q[0].data[63:32], 32'h8000_0000);
    chk("model_56_b2w15", exp_q[1].data[31:0], 32'h0000_01C0);
    drive_msg(1'b0, 1000);
    drain();

    // 64 bytes: marker spills into the length block
    set_msg(64, 9);
    model_push();
    chk("model_64_b2w0", exp_q[1].data[511:480], 32'h8000_0000);
    chk("model_64_b2w15", exp_q[1].data[31:0], 32'h0000_0200);
    drive_msg(1'b0, 1000);
    drain();

    // Boundaries around the length slots, oversized in_bytes, and a three-block message
    set_msg(55, 1);  model_push(); drive_msg(1'b0, 1000); drain();
    set_msg(59, 2);  model_push(); drive_msg(1'b0, 1000); drain();
    set_msg(60, 3);  model_push(); drive_msg(1'b0, 1000); drain();
    set_msg(52, 4);  model_push(); drive_msg(1'b0, 1000); drain();
    set_msg(8, 7);   model_push(); drive_msg(1'b1, 1000); drain();
    set_msg(130, 11);
    model_push();
    chk("model_130_nblk", exp_q.size(), 3);
    drive_msg(1'b0, 1000);
    drain();

    // Backpressure: block held five cycles with in_ready low
    blk_ready = 1'b0;
    msg = '{8'h61, 8'h62, 8'h63};
    model_push();
    drive_msg(1'b0, 1000);
    chk("latency_valid", blk_valid, 1'b1);
    repeat (5) @(posedge clk_i);
    #1;
    chk("bp_valid", blk_valid, 1'b1);
    chk("bp_in_ready", in_ready, 1'b0);
    blk_ready = 1'b1;
    drain();

    // Back-to-back three-byte messages
    msg = '{8'h61, 8'h62, 8'h63}; model_push(); drive_msg(1'b0, 1000);
    msg = '{8'h78, 8'h79, 8'h7A}; model_push(); drive_msg(1'b0, 1000);
    drain();

    // Reset after 7 words of a 20-word message
    set_msg(80, 21);
    drive_msg(1'b0, 7);
    rst_ni = 1'b0;
    #3;
    chk_reset_outputs("mid_rst");
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    msg = '{8'h61, 8'h62, 8'h63};
    model_push();
    drive_msg(1'b0, 1000);
    drain();

    // Reset while a block is stalled in SEND
    blk_ready = 1'b0;
    set_msg(20, 17);
    drive_msg(1'b0, 1000);
    wait_valid();
    rst_ni = 1'b0;
    #3;
    chk_reset_outputs("send_rst");
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    blk_ready = 1'b1;
    @(posedge clk_i);
    #1;
    msg = '{8'h61, 8'h62, 8'h63};
    model_push();
    drive_msg(1'b0, 1000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
